mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data RAM between the IF stage (fetch)
//  and the MEM stage (lw/sw) of the pipelined MIPS core. Accesses take MEM_LAT

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the IF (fetch) and
// MEM (load/store) stages. One access is in flight at a time; each access
// issues in IDLE and completes MEM_LAT cycles later with a one-cycle ready
// pulse. Conflicts in IDLE are resolved round-robin, first conflict to MEM.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              IF_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              MEM_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_MEM
    } state_t;

    typedef enum logic {
        G_IF,
        G_MEM
    } grant_t;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    grant_t            last_grant_q, last_grant_d;
    logic              store_q,      store_d;
    logic [DATA_W-1:0] if_hold_q,    if_hold_d;
    logic [DATA_W-1:0] mem_hold_q,   mem_hold_d;

    logic mem_req;
    assign mem_req = mem_rd | mem_wr;

    // Stalls follow request and ready combinationally.
    assign IF_stall  = if_req  & ~if_ready;
    assign MEM_stall = mem_req & ~mem_ready;

    // State, latency counter, round-robin pointer and read-data hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= G_IF;
            store_q      <= 1'b0;
            if_hold_q    <= '0;
            mem_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            store_q      <= store_d;
            if_hold_q    <= if_hold_d;
            mem_hold_q   <= mem_hold_d;
        end
    end

    // Grant/issue in IDLE, count down while busy, deliver on cnt==0.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        store_d      = store_q;
        if_hold_d    = if_hold_q;
        mem_hold_d   = mem_hold_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        if_ready     = 1'b0;
        mem_ready    = 1'b0;
        if_rdata     = if_hold_q;
        mem_rdata    = mem_hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_req && (!if_req || last_grant_q == G_IF)) begin
                    ram_en       = 1'b1;
                    ram_we       = mem_wr;
                    ram_addr     = mem_addr;
                    ram_wdata    = mem_wr ? mem_wdata : '0;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_BUSY_MEM;
                    last_grant_d = G_MEM;
                    store_d      = mem_wr;
                end else if (if_req) begin
                    ram_en       = 1'b1;
                    ram_addr     = if_addr;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_BUSY_IF;
                    last_grant_d = G_IF;
                    store_d      = 1'b0;
                end
            end
            S_BUSY_IF: begin
                if (cnt_q == '0) begin
                    if_ready  = 1'b1;
                    if_rdata  = ram_rdata;
                    if_hold_d = ram_rdata;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BUSY_MEM: begin
                if (cnt_q == '0) begin
                    mem_ready = 1'b1;
                    if (!store_q) begin
                        mem_rdata  = ram_rdata;
                        mem_hold_d = ram_rdata;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset silences every output in the reset cycle itself, including
        // the response of an access that was in flight.
        if (rst) begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
            if_ready  = 1'b0;
            mem_ready = 1'b0;
            if_rdata  = '0;
            mem_rdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=2 and one
// at MEM_LAT=1 share stimulus; each has its own latency-accurate RAM model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata;

    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, IF_stall, mem_ready, MEM_stall, ram_en, ram_we;
    logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        if_ready1, IF_stall1, mem_ready1, MEM_stall1, ram_en1, ram_we1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .IF_stall(IF_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .MEM_stall(MEM_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1),
        .if_ready(if_ready1), .IF_stall(IF_stall1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata1),
        .mem_ready(mem_ready1), .MEM_stall(MEM_stall1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    // RAM model: read data is only valid exactly MEM_LAT cycles after issue.
    logic [31:0] ram [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 32'hA5A50000;
    endfunction

    logic        s1_v = 1'b0, s2_v = 1'b0, t1_v = 1'b0;
    logic [31:0] s1_d = '0, s2_d = '0, t1_d = '0;

    always @(posedge clk) begin
        s1_v <= ram_en & ~ram_we;
        s1_d <= rd(ram_addr);
        s2_v <= s1_v;
        s2_d <= s1_d;
        t1_v <= ram_en1 & ~ram_we1;
        t1_d <= rd(ram_addr1);
        if (ram_en && ram_we)   ram[ram_addr]  = ram_wdata;
        if (ram_en1 && ram_we1) ram[ram_addr1] = ram_wdata1;
    end

    assign ram_rdata  = s2_v ? s2_d : 32'hBAD0BAD0;
    assign ram_rdata1 = t1_v ? t1_d : 32'hBAD0BAD0;

    // Scoreboard: expected issues and expected responses, keyed by cycle.
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { int cyc; logic [31:0] data; } rsp_t;
    iss_t iq[$];
    rsp_t ifq[$];
    rsp_t mq[$];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] if_last, mem_last;

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        iq.delete(); ifq.delete(); mq.delete();
        if_last = '0; mem_last = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
        if_addr = 32'h44; mem_addr = 32'h88; mem_wdata = 32'h1234;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ram_en, ram_we, ram_addr, ram_wdata, if_ready, mem_ready, if_rdata, mem_rdata} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs k%0d: en=%b we=%b addr=%h wd=%h ifr=%b mr=%b ifd=%h md=%h, want all 0",
                         k, ram_en, ram_we, ram_addr, ram_wdata, if_ready, mem_ready, if_rdata, mem_rdata);
            end
            n_cmp++;
            if ({ram_en1, ram_we1, ram_addr1, ram_wdata1, if_ready1, mem_ready1, if_rdata1, mem_rdata1} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs_lat1 k%0d: outputs not all 0", k);
            end
            @(posedge clk); #1;
        end
    endtask

    // Test 1: single fetch, completion after MEM_LAT, data held afterwards.
    task automatic test_fetch();
        bit   e_iss, e_ir, e_mr;
        iss_t ie;
        rsp_t re;
        do_reset();
        ram[32'h40] = 32'h8C220004;
        if_req = 1'b1; if_addr = 32'h40;
        iq.push_back('{0, 1'b0, 32'h40, 32'h0});
        ifq.push_back('{2, 32'h8C220004});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e_iss = iq.size() > 0 && iq[0].cyc == c;
            e_ir  = ifq.size() > 0 && ifq[0].cyc == c;
            e_mr  = 1'b0;
            n_cmp++;
            if (ram_en !== e_iss) begin n_err++; $display("FAIL fetch_ram_en c%0d: got %b want %b", c, ram_en, e_iss); end
            if (e_iss) begin
                ie = iq.pop_front(); n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== {ie.we, ie.addr, ie.wdata}) begin
                    n_err++; $display("FAIL fetch_issue c%0d: we=%b addr=%h wd=%h want %b %h %h", c, ram_we, ram_addr, ram_wdata, ie.we, ie.addr, ie.wdata);
                end
            end
            n_cmp++;
            if (if_ready !== e_ir) begin n_err++; $display("FAIL fetch_if_ready c%0d: got %b want %b", c, if_ready, e_ir); end
            if (e_ir) begin re = ifq.pop_front(); if_last = re.data; end
            n_cmp++;
            if (if_rdata !== if_last) begin n_err++; $display("FAIL fetch_if_rdata c%0d: got %h want %h", c, if_rdata, if_last); end
            n_cmp++;
            if (IF_stall !== (if_req && !e_ir)) begin n_err++; $display("FAIL fetch_IF_stall c%0d: got %b want %b", c, IF_stall, if_req && !e_ir); end
            n_cmp++;
            if (mem_ready !== e_mr) begin n_err++; $display("FAIL fetch_mem_ready c%0d: got %b want 0", c, mem_ready); end
            @(posedge clk); #1;
            if (c == 2) if_req = 1'b0;
        end
    endtask

    // Tests 2/3: both requesters held; grants alternate MEM, IF, MEM, IF.
    task automatic test_back_to_back();
        bit   e_iss, e_ir, e_mr;
        iss_t ie;
        rsp_t re;
        do_reset();
        if_req = 1'b1; if_addr = 32'h200;
        mem_rd = 1'b1; mem_addr = 32'h300;
        iq.push_back('{0, 1'b0, 32'h300, 32'h0});
        iq.push_back('{3, 1'b0, 32'h200, 32'h0});
        iq.push_back('{6, 1'b0, 32'h304, 32'h0});
        iq.push_back('{9, 1'b0, 32'h204, 32'h0});
        mq.push_back('{2, rd(32'h300)});
        ifq.push_back('{5, rd(32'h200)});
        mq.push_back('{8, rd(32'h304)});
        ifq.push_back('{11, rd(32'h204)});
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            e_iss = iq.size() > 0 && iq[0].cyc == c;
            e_ir  = ifq.size() > 0 && ifq[0].cyc == c;
            e_mr  = mq.size() > 0 && mq[0].cyc == c;
            n_cmp++;
            if (ram_en !== e_iss) begin n_err++; $display("FAIL rr_ram_en c%0d: got %b want %b", c, ram_en, e_iss); end
            if (e_iss) begin
                ie = iq.pop_front(); n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== {ie.we, ie.addr, ie.wdata}) begin
                    n_err++; $display("FAIL rr_issue c%0d: we=%b addr=%h wd=%h want %b %h %h", c, ram_we, ram_addr, ram_wdata, ie.we, ie.addr, ie.wdata);
                end
            end else begin
                n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== '0) begin n_err++; $display("FAIL rr_idle_bus c%0d: addr=%h wd=%h we=%b want 0", c, ram_addr, ram_wdata, ram_we); end
            end
            n_cmp++;
            if (if_ready !== e_ir) begin n_err++; $display("FAIL rr_if_ready c%0d: got %b want %b", c, if_ready, e_ir); end
            if (e_ir) begin re = ifq.pop_front(); if_last = re.data; end
            n_cmp++;
            if (if_rdata !== if_last) begin n_err++; $display("FAIL rr_if_rdata c%0d: got %h want %h", c, if_rdata, if_last); end
            n_cmp++;
            if (mem_ready !== e_mr) begin n_err++; $display("FAIL rr_mem_ready c%0d: got %b want %b", c, mem_ready, e_mr); end
            if (e_mr) begin re = mq.pop_front(); mem_last = re.data; end
            n_cmp++;
            if (mem_rdata !== mem_last) begin n_err++; $display("FAIL rr_mem_rdata c%0d: got %h want %h", c, mem_rdata, mem_last); end
            n_cmp++;
            if (IF_stall !== (if_req && !e_ir)) begin n_err++; $display("FAIL rr_IF_stall c%0d: got %b want %b", c, IF_stall, if_req && !e_ir); end
            n_cmp++;
            if (MEM_stall !== (mem_rd && !e_mr)) begin n_err++; $display("FAIL rr_MEM_stall c%0d: got %b want %b", c, MEM_stall, mem_rd && !e_mr); end
            @(posedge clk); #1;
            if (c == 2)  mem_addr = 32'h304;
            if (c == 5)  if_addr  = 32'h204;
            if (c == 8)  mem_rd   = 1'b0;
            if (c == 11) if_req   = 1'b0;
        end
        n_cmp++;
        if (iq.size() + ifq.size() + mq.size() != 0) begin n_err++; $display("FAIL rr_drain: %0d events outstanding, want 0", iq.size() + ifq.size() + mq.size()); end
    endtask

    // Test 4: load, then store (dropped after issue); store leaves mem_rdata; readback.
    task automatic test_store();
        bit   e_iss, e_mr;
        iss_t ie;
        rsp_t re;
        do_reset();
        mem_rd = 1'b1; mem_addr = 32'h44;
        iq.push_back('{0, 1'b0, 32'h44, 32'h0});
        mq.push_back('{2, rd(32'h44)});
        iq.push_back('{3, 1'b1, 32'h100, 32'hDEADBEEF});
        iq.push_back('{6, 1'b0, 32'h100, 32'h0});
        mq.push_back('{8, 32'hDEADBEEF});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e_iss = iq.size() > 0 && iq[0].cyc == c;
            e_mr  = (c == 5) || (mq.size() > 0 && mq[0].cyc == c);
            n_cmp++;
            if (ram_en !== e_iss) begin n_err++; $display("FAIL st_ram_en c%0d: got %b want %b", c, ram_en, e_iss); end
            if (e_iss) begin
                ie = iq.pop_front(); n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== {ie.we, ie.addr, ie.wdata}) begin
                    n_err++; $display("FAIL st_issue c%0d: we=%b addr=%h wd=%h want %b %h %h", c, ram_we, ram_addr, ram_wdata, ie.we, ie.addr, ie.wdata);
                end
            end else begin
                n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== '0) begin n_err++; $display("FAIL st_idle_bus c%0d: addr=%h wd=%h we=%b want 0", c, ram_addr, ram_wdata, ram_we); end
            end
            n_cmp++;
            if (mem_ready !== e_mr) begin n_err++; $display("FAIL st_mem_ready c%0d: got %b want %b", c, mem_ready, e_mr); end
            if (e_mr && c != 5) begin re = mq.pop_front(); mem_last = re.data; end
            n_cmp++;
            if (mem_rdata !== mem_last) begin n_err++; $display("FAIL st_mem_rdata c%0d: got %h want %h", c, mem_rdata, mem_last); end
            n_cmp++;
            if (MEM_stall !== ((mem_rd || mem_wr) && !e_mr)) begin n_err++; $display("FAIL st_MEM_stall c%0d: got %b want %b", c, MEM_stall, (mem_rd || mem_wr) && !e_mr); end
            @(posedge clk); #1;
            if (c == 2) begin mem_rd = 1'b0; mem_wr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; end
            if (c == 3) begin mem_wr = 1'b0; mem_addr = 32'h999; mem_wdata = 32'h12345678; end
            if (c == 5) begin mem_rd = 1'b1; mem_addr = 32'h100; mem_wdata = '0; end
            if (c == 8) mem_rd = 1'b0;
        end
    endtask

    // Test 5: reset mid-access discards the response; a fresh fetch works.
    task automatic test_reset_mid();
        bit   e_iss, e_ir;
        iss_t ie;
        rsp_t re;
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        iq.push_back('{0, 1'b0, 32'h40, 32'h0});
        iq.push_back('{3, 1'b0, 32'h48, 32'h0});
        ifq.push_back('{5, rd(32'h48)});
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            e_iss = iq.size() > 0 && iq[0].cyc == c;
            e_ir  = ifq.size() > 0 && ifq[0].cyc == c;
            n_cmp++;
            if (ram_en !== e_iss) begin n_err++; $display("FAIL rm_ram_en c%0d: got %b want %b", c, ram_en, e_iss); end
            if (e_iss) begin
                ie = iq.pop_front(); n_cmp++;
                if ({ram_we, ram_addr} !== {ie.we, ie.addr}) begin n_err++; $display("FAIL rm_issue c%0d: we=%b addr=%h want %b %h", c, ram_we, ram_addr, ie.we, ie.addr); end
            end else begin
                n_cmp++;
                if ({ram_we, ram_addr, ram_wdata} !== '0) begin n_err++; $display("FAIL rm_idle_bus c%0d: addr=%h want 0", c, ram_addr); end
            end
            n_cmp++;
            if (if_ready !== e_ir) begin n_err++; $display("FAIL rm_if_ready c%0d: got %b want %b", c, if_ready, e_ir); end
            if (e_ir) begin re = ifq.pop_front(); if_last = re.data; end
            n_cmp++;
            if (if_rdata !== if_last) begin n_err++; $display("FAIL rm_if_rdata c%0d: got %h want %h", c, if_rdata, if_last); end
            n_cmp++;
            if (mem_ready !== 1'b0 || mem_rdata !== '0) begin n_err++; $display("FAIL rm_mem_side c%0d: ready=%b data=%h want 0", c, mem_ready, mem_rdata); end
            @(posedge clk); #1;
            if (c == 0) begin rst = 1'b1; if_req = 1'b0; if_addr = '0; if_last = '0; end
            if (c == 1) rst = 1'b0;
            if (c == 2) begin if_req = 1'b1; if_addr = 32'h48; end
            if (c == 5) if_req = 1'b0;
        end
    endtask

    // Test 6: MEM_LAT=1 instance, back-to-back loads every other cycle.
    task automatic test_lat1();
        bit   e_iss, e_mr;
        iss_t ie;
        rsp_t re;
        do_reset();
        mem_rd = 1'b1; mem_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            iq.push_back('{2 * k, 1'b0, 32'h80 + 32'(4 * k), 32'h0});
            mq.push_back('{2 * k + 1, rd(32'h80 + 32'(4 * k))});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e_iss = iq.size() > 0 && iq[0].cyc == c;
            e_mr  = mq.size() > 0 && mq[0].cyc == c;
            n_cmp++;
            if (ram_en1 !== e_iss) begin n_err++; $display("FAIL l1_ram_en c%0d: got %b want %b", c, ram_en1, e_iss); end
            if (e_iss) begin
                ie = iq.pop_front(); n_cmp++;
                if ({ram_we1, ram_addr1, ram_wdata1} !== {ie.we, ie.addr, ie.wdata}) begin
                    n_err++; $display("FAIL l1_issue c%0d: we=%b addr=%h want %b %h", c, ram_we1, ram_addr1, ie.we, ie.addr);
                end
            end
            n_cmp++;
            if (mem_ready1 !== e_mr) begin n_err++; $display("FAIL l1_mem_ready c%0d: got %b want %b", c, mem_ready1, e_mr); end
            if (e_mr) begin re = mq.pop_front(); mem_last = re.data; end
            n_cmp++;
            if (mem_rdata1 !== mem_last) begin n_err++; $display("FAIL l1_mem_rdata c%0d: got %h want %h", c, mem_rdata1, mem_last); end
            n_cmp++;
            if (MEM_stall1 !== (mem_rd && !e_mr)) begin n_err++; $display("FAIL l1_MEM_stall c%0d: got %b want %b", c, MEM_stall1, mem_rd && !e_mr); end
            n_cmp++;
            if ({if_ready1, IF_stall1, if_rdata1} !== '0) begin n_err++; $display("FAIL l1_if_side c%0d: ready=%b stall=%b data=%h want 0", c, if_ready1, IF_stall1, if_rdata1); end
            @(posedge clk); #1;
            if (c == 1) mem_addr = 32'h84;
            if (c == 3) mem_addr = 32'h88;
            if (c == 5) mem_rd = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        if_last = '0; mem_last = '0;
        @(posedge clk); #1;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store();
        test_reset_mid();
        test_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
